rtc_preset_arbiter: RTL
=======================

# rtc_preset_arbiter

Controller that owns the preset path of the RTC time counter. It shares that path between two requesters: the APB register file and the IR controller. It arbitrates simultaneous requests round-robin and validates the requested calendar value. It applies a valid preset to the counter only in a cycle with no 1 Hz tick, and returns a per-requester acknowledge with an error flag. It sits between the register file / IR controller and the time counter's enable/preset inputs.

## Interface
- TIME_W, 37, packed time word width. Fixed layout, LSB first:
  - sec[5:0], min[11:6], hour[16:12], mode[17], dow[20:18]
  - dom[25:21], month[29:26], year[36:30]; year is years since 2000.
- CNT_W, 8, reject counter width.

Ports:
- clk_i  in  1  block clock; same domain as the time counter preset/enable logic.
- rst_i  in  1  synchronous, active-high reset.
- tick_i  in  1  single-cycle 1 Hz advance strobe seen by the time counter.
- run_i  in  1  software run enable, passed to enable_o outside APPLY.
- reg_req_i  in  1  register-file preset request; level, held until reg_ack_o.
- reg_time_i  in  TIME_W  register-file requested time; stable while reg_req_i=1.
- ir_req_i  in  1  IR preset request; level, held until ir_ack_o.
- ir_time_i  in  TIME_W  IR requested time; stable while ir_req_i=1.
- reg_ack_o  out  1  one-cycle completion pulse to the register file.
- ir_ack_o  out  1  one-cycle completion pulse to IR.
- err_o  out  1  valid with an ack; 1 = request rejected, counter untouched.
- busy_o  out  1  1 in any state other than IDLE.
- enable_o  out  1  time counter enable.
- preset_o  out  1  one-cycle time counter preset strobe.
- preset_time_o  out  TIME_W  value loaded into the counter; valid when preset_o=1.
- reject_cnt_o  out  CNT_W  saturating count of rejected requests.

## Operation
States and transitions:
- IDLE: if any req is high, pick a winner, latch its time into pend, record grant, go to CHECK.
- CHECK: evaluate validity of pend. Invalid → RESP with err=1. Valid → APPLY.
- APPLY: if tick_i=0, drive preset_o=1 with preset_time_o=pend and go to RESP. If tick_i=1, stay in APPLY.
- RESP: pulse the ack of the granted requester, drive err_o, go to IDLE.

Arbitration:
- Round-robin on a last_grant register. On a tie, grant the requester that was not last granted.
- A single requester always wins regardless of last_grant.
- Reset last_grant=IR, so the first tie goes to REG.
- last_grant updates in IDLE when a grant is made.

Validity (all must hold):
- sec<60, min<60, dow in 1..7, month in 1..12, year<100.
- hour: if mode=0 (24 h), hour<24. If mode=1 (12 h), hour in 1..12.
- dom in 1..days(month):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - month 2: 29 if year[1:0]==0, else 28.

Outputs and counters:
- enable_o = run_i, except 0 for every cycle spent in APPLY. This freezes the counter while a preset is pending.
- reject_cnt_o increments by 1 in RESP when err=1 and saturates at 2^CNT_W-1.
- Requests arriving in any non-IDLE state wait. A non-granted requester holding req is served next.
- A requester must drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.

Reset (rst_i=1 at a clock edge, including mid-operation):
- state=IDLE, pend=0, last_grant=IR, reject count=0.
- All outputs 0 (enable_o follows run_i from the first cycle after reset).
- No ack is issued for an aborted request.

## Timing
- Request sampled in IDLE at cycle N.
- CHECK at N+1.
- Valid request with tick_i=0: preset_o at N+2, ack/err at N+3. Minimum latency 3 cycles from sampling to ack.
- Each cycle with tick_i=1 in APPLY adds one cycle. preset_o and tick_i are never 1 in the same cycle.
- Invalid request: ack with err_o=1 at N+2. preset_o is never asserted.
- err_o is 0 whenever both acks are 0.
- A back-to-back request is sampled in IDLE at earliest one cycle after RESP.
- preset_time_o holds pend continuously. It is 0 after reset.

## Test plan
- REG requests 12:34:56, mode=0, dow=3, 15/06/24, tick_i=0 → preset_o at +2 with that word; reg_ack_o=1 and err_o=0 at +3; enable_o=0 only in the APPLY cycle.
- Both requesters request in the same cycle after reset → REG served first. IR is served next without IR deasserting, with ir_ack_o 4 cycles after reg_ack_o.
- IR requests dom=29, month=2: year=23 → err_o=1, no preset, reject count=1. Year=24 → accepted. Dom=31, month=4 → rejected.
- tick_i held 1 for 3 cycles during APPLY → preset_o delayed exactly 3 cycles; never coincident with tick_i.
- 300 invalid requests (sec=60) → reject_cnt_o saturates at 255.
- rst_i asserted in APPLY → no preset_o and no ack; all outputs 0 the next cycle; last_grant=IR.

Source files
------------

// File: rtl/rtc_preset_arbiter.sv
// Owns the RTC time-counter preset path: round-robin between the register file and IR,
// validates the requested calendar word, and loads it into the counter in a cycle with no 1 Hz tick.
module rtc_preset_arbiter #(
   parameter int TIME_W = 37,
   parameter int CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tick_i,
   input  logic              run_i,
   input  logic              reg_req_i,
   input  logic [TIME_W-1:0] reg_time_i,
   input  logic              ir_req_i,
   input  logic [TIME_W-1:0] ir_time_i,
   output logic              reg_ack_o,
   output logic              ir_ack_o,
   output logic              err_o,
   output logic              busy_o,
   output logic              enable_o,
   output logic              preset_o,
   output logic [TIME_W-1:0] preset_time_o,
   output logic [CNT_W-1:0]  reject_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_APPLY, S_RESP} state_t;

   localparam logic GNT_REG = 1'b0;
   localparam logic GNT_IR  = 1'b1;

   state_t             state_q, state_d;
   logic [TIME_W-1:0]  pend_q, pend_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [5:0] f_sec, f_min;
   logic [4:0] f_hour, f_dom;
   logic       f_mode;
   logic [2:0] f_dow;
   logic [3:0] f_month;
   logic [6:0] f_year;
   logic [4:0] days_in_month;
   logic       hour_ok;
   logic       pend_valid;
   logic       winner;

   assign f_sec   = pend_q[5:0];
   assign f_min   = pend_q[11:6];
   assign f_hour  = pend_q[16:12];
   assign f_mode  = pend_q[17];
   assign f_dow   = pend_q[20:18];
   assign f_dom   = pend_q[25:21];
   assign f_month = pend_q[29:26];
   assign f_year  = pend_q[36:30];

   // Every year since 2000 divisible by four is a leap year within the 0..99 range.
   always_comb begin
      days_in_month = 5'd31;
      case (f_month)
         4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
         4'd2:                    days_in_month = (f_year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 days_in_month = 5'd31;
      endcase
   end

   assign hour_ok = f_mode ? ((f_hour >= 5'd1) && (f_hour <= 5'd12)) : (f_hour < 5'd24);

   assign pend_valid = (f_sec < 6'd60) && (f_min < 6'd60) && hour_ok &&
                       (f_dow != 3'd0) &&
                       (f_month >= 4'd1) && (f_month <= 4'd12) &&
                       (f_dom >= 5'd1) && (f_dom <= days_in_month) &&
                       (f_year < 7'd100);

   // A tie goes to whichever requester was not served last.
   always_comb begin
      winner = GNT_REG;
      if (reg_req_i && ir_req_i) begin
         winner = (last_grant_q == GNT_IR) ? GNT_REG : GNT_IR;
      end else if (ir_req_i) begin
         winner = GNT_IR;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (reg_req_i || ir_req_i) begin
               grant_d      = winner;
               last_grant_d = winner;
               pend_d       = (winner == GNT_IR) ? ir_time_i : reg_time_i;
               state_d      = S_CHECK;
            end
         end
         S_CHECK: begin
            err_d   = ~pend_valid;
            state_d = pend_valid ? S_APPLY : S_RESP;
         end
         S_APPLY: begin
            if (!tick_i) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (err_q && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         pend_q       <= '0;
         grant_q      <= GNT_REG;
         last_grant_q <= GNT_IR;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   // Strobes are masked while reset is asserted so an aborted request never loads or acks.
   assign preset_o      = (state_q == S_APPLY) && !tick_i && !rst_i;
   assign reg_ack_o     = (state_q == S_RESP) && (grant_q == GNT_REG) && !rst_i;
   assign ir_ack_o      = (state_q == S_RESP) && (grant_q == GNT_IR) && !rst_i;
   assign err_o         = (state_q == S_RESP) && err_q && !rst_i;
   assign busy_o        = (state_q != S_IDLE);
   assign enable_o      = run_i && (state_q != S_APPLY);
   assign preset_time_o = pend_q;
   assign reject_cnt_o  = cnt_q;

endmodule
